// File: rtl/mmio_stream_responder_if.sv
// Bus and stream signals of mmio_stream_responder: processor-side we/addr/din/dout
// plus the valid/ready stream toward the downstream consumer.
interface mmio_stream_responder_if #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    // Processor plus stream consumer side
    modport master (
        output we,
        output addr,
        output din,
        output out_ready,
        input  dout,
        input  out_data,
        input  out_valid
    );

    // Peripheral side
    modport slave (
        input  we,
        input  addr,
        input  din,
        input  out_ready,
        output dout,
        output out_data,
        output out_valid
    );
endinterface

// File: rtl/mmio_stream_responder.sv
// MMIO-write to valid/ready stream bridge with a show-ahead FIFO and a 4-register window.
// Optional interrupt output is enabled by defining MMIO_STREAM_RESPONDER_IRQ_EN.
module mmio_stream_responder #(
    parameter int unsigned           ADDR_WIDTH = 10,
    parameter int unsigned           DATA_WIDTH = 16,
    parameter int unsigned           DEPTH      = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 10'h3F0
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef MMIO_STREAM_RESPONDER_IRQ_EN
    output logic                  irq,
`endif
    mmio_stream_responder_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_overflow;
    logic [15:0]           r_txcount;
    logic [DATA_WIDTH-1:0] r_dout;

    logic [ADDR_WIDTH-1:0] w_off;
    logic                  w_in_win;
    logic                  w_wr_data;
    logic                  w_wr_ctrl;
    logic                  w_wr_txcnt;
    logic                  w_flush;
    logic                  w_clr_ovf;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push_ok;
    logic                  w_ovf_set;
    logic [15:0]           w_status;

    assign w_off      = bus.addr - BASE_ADDR;
    assign w_in_win   = (w_off < ADDR_WIDTH'(4));
    assign w_wr_data  = bus.we && w_in_win && (w_off[1:0] == 2'd0);
    assign w_wr_ctrl  = bus.we && w_in_win && (w_off[1:0] == 2'd2);
    assign w_wr_txcnt = bus.we && w_in_win && (w_off[1:0] == 2'd3);
    assign w_flush    = w_wr_ctrl && bus.din[0];
    assign w_clr_ovf  = w_wr_ctrl && bus.din[1];

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_pop      = !w_empty && bus.out_ready;
    // A same-edge pop frees a slot, so a push into a full FIFO is still accepted.
    assign w_push_ok  = w_wr_data && !w_flush && (!w_full || w_pop);
    assign w_ovf_set  = w_wr_data && !w_flush && w_full && !w_pop;

    assign w_status   = {r_overflow, w_full, w_empty, 5'b0, 8'(r_count)};

    assign bus.out_valid = !w_empty;
    assign bus.out_data  = r_mem[r_rd_ptr];
    assign bus.dout      = r_dout;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= bus.din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_txcount  <= '0;
            r_dout     <= '0;
        end else begin
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push_ok) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop);
            end

            // Set beats clear when both land on the same edge.
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (w_clr_ovf) begin
                r_overflow <= 1'b0;
            end

            if (w_wr_txcnt) begin
                r_txcount <= '0;
            end else if (w_pop) begin
                r_txcount <= r_txcount + 16'd1;
            end

            if (!w_in_win) begin
                r_dout <= '0;
            end else begin
                unique case (w_off[1:0])
                    2'd1:    r_dout <= DATA_WIDTH'(w_status);
                    2'd3:    r_dout <= DATA_WIDTH'(r_txcount);
                    default: r_dout <= '0;
                endcase
            end
        end
    end

`ifdef MMIO_STREAM_RESPONDER_IRQ_EN
    logic r_irq_en;
    logic r_irq;

    // Evaluated from already-registered state, so irq trails the cause by one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_irq_en <= bus.din[2];
            end
            r_irq <= r_irq_en && (w_empty || r_overflow);
        end
    end

    assign irq = r_irq;
`endif
endmodule

// File: tb/tb_mmio_stream_responder.sv
// Self-checking bench for mmio_stream_responder: directed steps then randomized traffic
// compared against a queue-based reference model.
module tb_mmio_stream_responder;
    localparam int unsigned AW    = 10;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 16;
    localparam logic [9:0]  BASE  = 10'h3F0;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mmio_stream_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef MMIO_STREAM_RESPONDER_IRQ_EN
    logic irq;
`endif

    mmio_stream_responder #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE)
    ) dut (
        .clk  (clk),
        .reset(reset),
`ifdef MMIO_STREAM_RESPONDER_IRQ_EN
        .irq  (irq),
`endif
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [15:0] m_q[$];
    logic        m_ovf;
    logic [15:0] m_tx;
    logic        m_en;
    logic        m_irq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] m_status();
        return {m_ovf, m_q.size() == DEPTH, m_q.size() == 0, 5'b0, 8'(m_q.size())};
    endfunction

    task automatic do_reset();
        reset         = 1'b1;
        bus.we        = 1'b0;
        bus.addr      = '0;
        bus.din       = '0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_q.delete();
        m_ovf = 1'b0;
        m_tx  = '0;
        m_en  = 1'b0;
        m_irq = 1'b0;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_dout", 32'(bus.dout), 32'd0);
`ifdef MMIO_STREAM_RESPONDER_IRQ_EN
        chk("rst_irq", 32'(irq), 32'd0);
`endif
    endtask

    // One bus cycle: drive, check stream outputs, clock, update model, check dout.
    task automatic cycle(input logic w, input logic [9:0] a, input logic [15:0] d,
                         input logic rdy);
        logic [9:0]  off;
        logic        inwin;
        logic [15:0] exp_dout;
        logic        pop;
        logic        push;
        logic        flush;
        logic        clr;
        logic        ovf_set;
        logic        nirq;
        bus.we        = w;
        bus.addr      = a;
        bus.din       = d;
        bus.out_ready = rdy;
        chk("out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) chk("out_data", 32'(bus.out_data), 32'(m_q[0]));
        off   = a - BASE;
        inwin = (off < 10'd4);
        exp_dout = '0;
        if (inwin && off == 10'd1) exp_dout = m_status();
        else if (inwin && off == 10'd3) exp_dout = m_tx;
        nirq  = m_en && (m_q.size() == 0 || m_ovf);
        pop   = rdy && (m_q.size() != 0);
        push  = w && inwin && off == 10'd0;
        flush = w && inwin && off == 10'd2 && d[0];
        clr   = w && inwin && off == 10'd2 && d[1];
        @(posedge clk);
        #1;
        if (pop) begin
            void'(m_q.pop_front());
            m_tx++;
        end
        ovf_set = 1'b0;
        if (push && !flush) begin
            if (m_q.size() < DEPTH) m_q.push_back(d);
            else ovf_set = 1'b1;
        end
        if (flush) m_q.delete();
        if (clr) m_ovf = 1'b0;
        if (ovf_set) m_ovf = 1'b1;
        if (w && inwin && off == 10'd3) m_tx = '0;
        if (w && inwin && off == 10'd2) m_en = d[2];
        m_irq = nirq;
        chk("dout", 32'(bus.dout), 32'(exp_dout));
`ifdef MMIO_STREAM_RESPONDER_IRQ_EN
        chk("irq", 32'(irq), 32'(m_irq));
`endif
    endtask

    initial begin
        do_reset();

        cycle(1'b0, BASE + 10'd1, 16'h0, 1'b0);
        chk("status_after_reset", 32'(bus.dout), 32'h2000);

        // Fill with consumer stalled, then overflow
        for (int i = 0; i < 16; i++) cycle(1'b1, BASE, 16'(i), 1'b0);
        cycle(1'b0, BASE + 10'd1, 16'h0, 1'b0);
        chk("status_full", 32'(bus.dout), 32'h4010);
        chk("head_word", 32'(bus.out_data), 32'h0000);
        cycle(1'b1, BASE, 16'h00AA, 1'b0);
        cycle(1'b0, BASE + 10'd1, 16'h0, 1'b0);
        chk("status_overflow", 32'(bus.dout), 32'hC010);

        // Drain in order, one per cycle
        for (int i = 0; i < 16; i++) begin
            chk("drain_order", 32'(bus.out_data), 32'(i));
            cycle(1'b0, BASE + 10'd1, 16'h0, 1'b1);
        end
        cycle(1'b0, BASE + 10'd1, 16'h0, 1'b0);
        chk("status_drained", 32'(bus.dout), 32'hA000);
        cycle(1'b0, BASE + 10'd3, 16'h0, 1'b0);
        chk("txcount_16", 32'(bus.dout), 32'd16);
        cycle(1'b1, BASE + 10'd2, 16'h0002, 1'b0);
        cycle(1'b0, BASE + 10'd1, 16'h0, 1'b0);
        chk("status_ovf_cleared", 32'(bus.dout), 32'h2000);

        // Push into a full FIFO while a pop happens on the same edge
        for (int i = 0; i < 16; i++) cycle(1'b1, BASE, 16'h0100 + 16'(i), 1'b0);
        cycle(1'b1, BASE, 16'h0BEE, 1'b1);
        cycle(1'b0, BASE + 10'd1, 16'h0, 1'b0);
        chk("status_push_pop_full", 32'(bus.dout), 32'h4010);
        for (int i = 0; i < 15; i++) cycle(1'b0, BASE + 10'd1, 16'h0, 1'b1);
        chk("last_word", 32'(bus.out_data), 32'h0BEE);
        cycle(1'b0, BASE + 10'd1, 16'h0, 1'b1);

        // Flush with a same-edge handshake
        cycle(1'b1, BASE + 10'd3, 16'hFFFF, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, BASE, 16'h0200 + 16'(i), 1'b0);
        cycle(1'b1, BASE + 10'd2, 16'h0001, 1'b1);
        cycle(1'b0, BASE + 10'd1, 16'h0, 1'b0);
        chk("status_flushed", 32'(bus.dout), 32'h2000);
        cycle(1'b0, BASE + 10'd3, 16'h0, 1'b0);
        chk("txcount_flush_edge", 32'(bus.dout), 32'd1);
        cycle(1'b1, 10'h000, 16'h1234, 1'b0);
        cycle(1'b0, BASE + 10'd1, 16'h0, 1'b0);
        chk("outside_write_ignored", 32'(bus.dout), 32'h2000);
        cycle(1'b0, 10'h005, 16'h0, 1'b0);
        chk("outside_read_zero", 32'(bus.dout), 32'h0);

`ifdef MMIO_STREAM_RESPONDER_IRQ_EN
        cycle(1'b1, BASE + 10'd2, 16'h0004, 1'b0);
        cycle(1'b0, 10'h000, 16'h0, 1'b0);
        chk("irq_empty", 32'(irq), 32'd1);
        cycle(1'b1, BASE, 16'h0007, 1'b0);
        cycle(1'b0, 10'h000, 16'h0, 1'b0);
        chk("irq_nonempty", 32'(irq), 32'd0);
        cycle(1'b0, 10'h000, 16'h0, 1'b1);
        cycle(1'b0, 10'h000, 16'h0, 1'b0);
        chk("irq_drained", 32'(irq), 32'd1);
`endif

        // Randomized traffic, with one mid-stream reset
        for (int n = 0; n < 800; n++) begin
            logic [9:0]  a;
            logic [15:0] d;
            logic        w;
            logic        rdy;
            int unsigned sel;
            if (n == 400) do_reset();
            sel = $urandom_range(0, 7);
            if (sel <= 2)       a = BASE;
            else if (sel == 3)  a = BASE + 10'd1;
            else if (sel == 4)  a = BASE + 10'd2;
            else if (sel == 5)  a = BASE + 10'd3;
            else                a = 10'($urandom_range(0, 1023));
            w   = ($urandom_range(0, 3) != 0);
            d   = 16'($urandom);
            rdy = (n < 400) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
            if (a == BASE + 10'd2) d[0] = ($urandom_range(0, 7) == 0);
            if (w && a == BASE + 10'd3) rdy = 1'b0;
            cycle(w, a, d, rdy);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
